// File: rtl/reg_group_arbiter.sv
// reg_group_arbiter: round-robin arbiter that serialises word writes
// from NUM_REQ requesters into one shared Groupsize-bit register group.
module reg_group_arbiter #(
  parameter  int Groupsize = 8,
  parameter  int NUM_REQ   = 4,
  parameter  int MAX_BURST = 4,
  parameter  int TIMEOUT   = 8,
  localparam int IdW       = $clog2(NUM_REQ)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*Groupsize-1:0] req_data,
  input  logic [NUM_REQ-1:0]           req_last,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic                         grant_valid,
  output logic [IdW-1:0]               grant_id,
  output logic [Groupsize-1:0]         data_out,
  output logic                         timeout_pulse
);

  localparam int BW = $clog2(MAX_BURST + 1);
  localparam int SW = $clog2(TIMEOUT + 1);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [IdW-1:0]       r_rr_ptr;
  logic [IdW-1:0]       w_rr_nxt;
  logic [IdW-1:0]       r_grant_id;
  logic [IdW-1:0]       w_gid_nxt;
  logic [BW-1:0]        r_beat_cnt;
  logic [BW-1:0]        w_beat_nxt;
  logic [SW-1:0]        r_stall_cnt;
  logic [SW-1:0]        w_stall_nxt;
  logic [Groupsize-1:0] r_data;
  logic [Groupsize-1:0] w_data_nxt;
  logic                 r_tp;
  logic                 w_tp_nxt;

  logic                 w_found;
  logic [IdW-1:0]       w_pick;
  int                   w_idx;
  logic [NUM_REQ-1:0]   w_ready;
  logic                 w_accept;
  logic [Groupsize-1:0] w_word;
  logic                 w_last;
  logic [IdW-1:0]       w_rr_inc;

  // Rotating priority search: first valid requester at or after rr_ptr.
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    w_idx   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_idx = (int'(r_rr_ptr) + k) % NUM_REQ;
      if (!w_found && req_valid[w_idx]) begin
        w_found = 1'b1;
        w_pick  = IdW'(w_idx);
      end
    end
  end

  // Ready is decoded purely from registered state, never from req_valid.
  always_comb begin
    w_ready = '0;
    if (r_state == BUSY) begin
      w_ready[r_grant_id] = 1'b1;
    end
  end

  assign w_accept = (r_state == BUSY) && req_valid[r_grant_id];
  assign w_word   = req_data[r_grant_id*Groupsize +: Groupsize];
  assign w_last   = req_last[r_grant_id];
  assign w_rr_inc = (r_grant_id == IdW'(NUM_REQ - 1)) ?
                    '0 : r_grant_id + IdW'(1);

  // Next-state: arbitrate in IDLE, stream/stall/release in BUSY.
  always_comb begin
    w_state_nxt = r_state;
    w_rr_nxt    = r_rr_ptr;
    w_gid_nxt   = r_grant_id;
    w_beat_nxt  = r_beat_cnt;
    w_stall_nxt = r_stall_cnt;
    w_data_nxt  = r_data;
    w_tp_nxt    = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_found) begin
          w_state_nxt = BUSY;
          w_gid_nxt   = w_pick;
          w_beat_nxt  = '0;
          w_stall_nxt = '0;
        end
      end
      BUSY: begin
        if (w_accept) begin
          w_data_nxt  = w_word;
          w_beat_nxt  = r_beat_cnt + BW'(1);
          w_stall_nxt = '0;
          if (w_last || (r_beat_cnt == BW'(MAX_BURST - 1))) begin
            w_state_nxt = IDLE;
            w_rr_nxt    = w_rr_inc;
          end
        end else if (r_stall_cnt == SW'(TIMEOUT - 1)) begin
          w_state_nxt = IDLE;
          w_rr_nxt    = w_rr_inc;
          w_tp_nxt    = 1'b1;
        end else begin
          w_stall_nxt = r_stall_cnt + SW'(1);
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State register; reset aborts any grant and clears the group.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_rr_ptr    <= '0;
      r_grant_id  <= '0;
      r_beat_cnt  <= '0;
      r_stall_cnt <= '0;
      r_data      <= '0;
      r_tp        <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_rr_ptr    <= w_rr_nxt;
      r_grant_id  <= w_gid_nxt;
      r_beat_cnt  <= w_beat_nxt;
      r_stall_cnt <= w_stall_nxt;
      r_data      <= w_data_nxt;
      r_tp        <= w_tp_nxt;
    end
  end

  assign req_ready     = w_ready;
  assign grant_valid   = (r_state == BUSY);
  assign grant_id      = r_grant_id;
  assign data_out      = r_data;
  assign timeout_pulse = r_tp;

endmodule

// File: tb/tb_reg_group_arbiter.sv
// tb_reg_group_arbiter: directed checks of arbitration order,
// burst cap, stall timeout and reset behaviour.
module tb_reg_group_arbiter;

  logic        clk;
  logic        reset;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_last;
  logic [3:0]  req_ready;
  logic        grant_valid;
  logic [1:0]  grant_id;
  logic [7:0]  data_out;
  logic        timeout_pulse;

  int n_assert;
  int n_fail;
  logic [7:0] prev;

  reg_group_arbiter #(
    .Groupsize(8),
    .NUM_REQ  (4),
    .MAX_BURST(4),
    .TIMEOUT  (8)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_last     (req_last),
    .req_ready    (req_ready),
    .grant_valid  (grant_valid),
    .grant_id     (grant_id),
    .data_out     (data_out),
    .timeout_pulse(timeout_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [3:0] rdy,
                         input logic gv, input logic [1:0] gid,
                         input logic [7:0] d, input logic tp);
    chk({tag, ".req_ready"}, 32'(req_ready), 32'(rdy));
    chk({tag, ".grant_valid"}, 32'(grant_valid), 32'(gv));
    chk({tag, ".grant_id"}, 32'(grant_id), 32'(gid));
    chk({tag, ".data_out"}, 32'(data_out), 32'(d));
    chk({tag, ".timeout_pulse"}, 32'(timeout_pulse), 32'(tp));
  endtask

  task automatic set_word(input int i, input logic [7:0] v);
    req_data[i*8 +: 8] = v;
  endtask

  initial begin
    n_assert  = 0;
    n_fail    = 0;
    reset     = 1'b1;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    #1;

    // reset with random inputs
    for (int i = 0; i < 3; i++) begin
      req_valid = 4'($urandom);
      req_data  = $urandom;
      req_last  = 4'($urandom);
      tick();
      chk_all("rst", 4'b0000, 1'b0, 2'd0, 8'h00, 1'b0);
    end
    reset     = 1'b0;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    tick();
    chk_all("idle", 4'b0000, 1'b0, 2'd0, 8'h00, 1'b0);

    // single requester, single word
    req_valid = 4'b0010;
    req_last  = 4'b0010;
    set_word(1, 8'hA5);
    chk("s2_pre_rdy", 32'(req_ready), 32'h0);
    tick();
    chk_all("s2_busy", 4'b0010, 1'b1, 2'd1, 8'h00, 1'b0);
    tick();
    chk_all("s2_acc", 4'b0000, 1'b0, 2'd1, 8'hA5, 1'b0);
    req_valid = '0;
    req_last  = '0;

    // reset puts rr_ptr back to 0
    reset = 1'b1;
    tick();
    chk_all("s3_rst", 4'b0000, 1'b0, 2'd0, 8'h00, 1'b0);
    reset = 1'b0;

    // all four valid, one word each: order 0,1,2,3,0
    req_valid = 4'b1111;
    req_last  = 4'b1111;
    for (int i = 0; i < 4; i++) set_word(i, 8'(8'h10 + i));
    prev = 8'h00;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk_all("s3_grant", 4'(1 << (k % 4)), 1'b1, 2'(k % 4), prev, 1'b0);
      tick();
      chk_all("s3_acc", 4'b0000, 1'b0, 2'(k % 4),
              8'(8'h10 + (k % 4)), 1'b0);
      prev = 8'(8'h10 + (k % 4));
    end
    req_valid = '0;
    req_last  = '0;

    // burst cap: req 2 streams without last, req 3 waits
    req_valid = 4'b1100;
    req_last  = 4'b1000;
    set_word(2, 8'h01);
    set_word(3, 8'h33);
    tick();
    chk_all("s4_grant", 4'b0100, 1'b1, 2'd2, 8'h10, 1'b0);
    for (int w = 1; w <= 4; w++) begin
      tick();
      if (w < 4)
        chk_all("s4_beat", 4'b0100, 1'b1, 2'd2, 8'(w), 1'b0);
      else
        chk_all("s4_rel", 4'b0000, 1'b0, 2'd2, 8'h04, 1'b0);
      set_word(2, 8'(w + 1));
    end
    tick();
    chk_all("s4_g3", 4'b1000, 1'b1, 2'd3, 8'h04, 1'b0);
    tick();
    chk_all("s4_a3", 4'b0000, 1'b0, 2'd3, 8'h33, 1'b0);
    req_valid = 4'b0100;
    tick();
    chk_all("s4_resume", 4'b0100, 1'b1, 2'd2, 8'h33, 1'b0);
    req_last = 4'b0100;
    tick();
    chk_all("s4_w5", 4'b0000, 1'b0, 2'd2, 8'h05, 1'b0);
    req_valid = '0;
    req_last  = '0;

    // stall timeout: req 1 accepts one word then stalls
    req_valid = 4'b0010;
    set_word(1, 8'h77);
    tick();
    chk_all("s5_grant", 4'b0010, 1'b1, 2'd1, 8'h05, 1'b0);
    tick();
    chk_all("s5_acc", 4'b0010, 1'b1, 2'd1, 8'h77, 1'b0);
    req_valid = 4'b0100;
    for (int s = 1; s < 8; s++) begin
      tick();
      chk_all("s5_stall", 4'b0010, 1'b1, 2'd1, 8'h77, 1'b0);
    end
    tick();
    chk_all("s5_tmo", 4'b0000, 1'b0, 2'd1, 8'h77, 1'b1);
    req_valid = 4'b0110;
    tick();
    chk_all("s5_rr", 4'b0100, 1'b1, 2'd2, 8'h77, 1'b0);
    set_word(2, 8'h22);
    req_last = 4'b0100;
    tick();
    chk_all("s5_a2", 4'b0000, 1'b0, 2'd2, 8'h22, 1'b0);
    req_valid = '0;
    req_last  = '0;

    // reset mid-burst
    req_valid = 4'b1000;
    set_word(3, 8'hC1);
    tick();
    chk_all("s6_grant", 4'b1000, 1'b1, 2'd3, 8'h22, 1'b0);
    tick();
    chk_all("s6_b1", 4'b1000, 1'b1, 2'd3, 8'hC1, 1'b0);
    set_word(3, 8'hC2);
    tick();
    chk_all("s6_b2", 4'b1000, 1'b1, 2'd3, 8'hC2, 1'b0);
    reset     = 1'b1;
    req_valid = '0;
    tick();
    chk_all("s6_rst", 4'b0000, 1'b0, 2'd0, 8'h00, 1'b0);
    reset     = 1'b0;
    req_valid = 4'b1010;
    tick();
    chk_all("s6_rr0", 4'b0010, 1'b1, 2'd1, 8'h00, 1'b0);
    req_valid = '0;

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
